// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - writeback arbiter port A / port B / register file write bundle
interface writeback_arbiter_if #(
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int REG_WIDTH_IN_BIT = 32
);
  logic                        a_valid;
  logic                        a_ready;
  logic [REG_ADDR_WIDTH-1:0]   a_addr;
  logic [REG_WIDTH_IN_BIT-1:0] a_data;

  logic                        b_valid;
  logic                        b_ready;
  logic [REG_ADDR_WIDTH-1:0]   b_addr;
  logic [REG_WIDTH_IN_BIT-1:0] b_data;
  logic [1:0]                  b_size;
  logic                        b_signed;

  logic                        write_enable;
  logic [REG_ADDR_WIDTH-1:0]   write_reg_addr;
  logic [REG_WIDTH_IN_BIT-1:0] write_data;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data, b_size, b_signed,
    input  a_ready, b_ready,
    input  write_enable, write_reg_addr, write_data
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data, b_size, b_signed,
    output a_ready, b_ready,
    output write_enable, write_reg_addr, write_data
  );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - serialises port A and FIFO-buffered port B results onto the register file write port
// Optional sub-word sign extension enabled by defining WB_SIGN_EXTEND_EN.
module writeback_arbiter #(
  parameter int REG_NUMBER        = 32,
  parameter int REG_ADDR_WIDTH    = $clog2(REG_NUMBER),
  parameter int REG_WIDTH_IN_BYTE = 4,
  parameter int REG_WIDTH_IN_BIT  = REG_WIDTH_IN_BYTE * 8,
  parameter int FIFO_DEPTH        = 4,
  parameter int STARVE_LIMIT      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  writeback_arbiter_if.slave   bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [REG_ADDR_WIDTH-1:0]   fifo_addr [FIFO_DEPTH];
  logic [REG_WIDTH_IN_BIT-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]              wr_ptr;
  logic [PTR_W:0]              rd_ptr;
  logic [CNT_W-1:0]            starve_cnt;

  logic                        empty;
  logic                        full;
  logic                        force_b;
  logic                        push;
  logic                        pop;
  logic                        accept_a;
  logic                        fill_bit;
  logic [REG_WIDTH_IN_BIT-1:0] ext_data;
  logic                        win_valid;
  logic [REG_ADDR_WIDTH-1:0]   win_addr;
  logic [REG_WIDTH_IN_BIT-1:0] win_data;

  logic                        we_q;
  logic [REG_ADDR_WIDTH-1:0]   addr_q;
  logic [REG_WIDTH_IN_BIT-1:0] data_q;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign force_b  = (starve_cnt == CNT_W'(STARVE_LIMIT)) && !empty;
  assign push     = bus.b_valid && bus.b_ready;
  assign accept_a = bus.a_valid && bus.a_ready;
  assign pop      = !empty && (force_b || !bus.a_valid);

  assign bus.a_ready = !reset && !force_b;
  assign bus.b_ready = !reset && !full;

`ifdef WB_SIGN_EXTEND_EN
  assign fill_bit = bus.b_signed && ((bus.b_size == 2'b00) ? bus.b_data[7] : bus.b_data[15]);
`else
  logic unused_b_signed;
  assign unused_b_signed = bus.b_signed;
  assign fill_bit        = 1'b0;
`endif

  always_comb begin
    ext_data = bus.b_data;
    case (bus.b_size)
      2'b00:   ext_data = {{(REG_WIDTH_IN_BIT-8){fill_bit}},  bus.b_data[7:0]};
      2'b01:   ext_data = {{(REG_WIDTH_IN_BIT-16){fill_bit}}, bus.b_data[15:0]};
      default: ext_data = bus.b_data;
    endcase
  end

  always_comb begin
    win_valid = accept_a || pop;
    win_addr  = bus.a_addr;
    win_data  = bus.a_data;
    if (pop) begin
      win_addr = fifo_addr[rd_ptr[PTR_W-1:0]];
      win_data = fifo_data[rd_ptr[PTR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr[PTR_W-1:0]] <= bus.b_addr;
      fifo_data[wr_ptr[PTR_W-1:0]] <= ext_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop || empty)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= win_valid && (win_addr != '0);
      if (win_valid && (win_addr != '0)) begin
        addr_q <= win_addr;
        data_q <= win_data;
      end
    end
  end

  assign bus.write_enable   = we_q;
  assign bus.write_reg_addr = addr_q;
  assign bus.write_data     = data_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - scoreboard bench for writeback_arbiter
module tb_writeback_arbiter;
  logic clk;
  logic reset;

  writeback_arbiter_if #(.REG_ADDR_WIDTH(5), .REG_WIDTH_IN_BIT(32)) bus ();

  writeback_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] addr, input logic [31:0] data);
    bus.a_valid = v;
    bus.a_addr  = addr;
    bus.a_data  = data;
  endtask

  task automatic set_b(input logic v, input logic [4:0] addr, input logic [31:0] data,
                       input logic [1:0] size, input logic sgn);
    bus.b_valid  = v;
    bus.b_addr   = addr;
    bus.b_data   = data;
    bus.b_size   = size;
    bus.b_signed = sgn;
  endtask

  // Scoreboard monitor: every register file write must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%0d:%h required=none", bus.write_reg_addr, bus.write_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({bus.write_reg_addr, bus.write_data} !== e) begin
          errors++;
          $display("FAIL write actual=%0d:%h required=%0d:%h",
                   bus.write_reg_addr, bus.write_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    set_a(1'b0, 5'd0, 32'h0);
    set_b(1'b0, 5'd0, 32'h0, 2'b10, 1'b0);
    step();
    step();
    check("rst_a_ready", {31'b0, bus.a_ready}, 32'd0);
    check("rst_b_ready", {31'b0, bus.b_ready}, 32'd0);
    check("rst_we", {31'b0, bus.write_enable}, 32'd0);
    check("rst_addr", {27'b0, bus.write_reg_addr}, 32'd0);
    check("rst_data", bus.write_data, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_a_ready", {31'b0, bus.a_ready}, 32'd1);
    check("post_rst_b_ready", {31'b0, bus.b_ready}, 32'd1);

    // Plain A write
    set_a(1'b1, 5'd5, 32'hDEADBEEF);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    step();
    set_a(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("a_latency_we", {31'b0, bus.write_enable}, 32'd1);
    step();

    // B byte and half
    set_b(1'b1, 5'd7, 32'h12345680, 2'b00, 1'b1);
    check("b_ready_idle", {31'b0, bus.b_ready}, 32'd1);
`ifdef WB_SIGN_EXTEND_EN
    exp_q.push_back({5'd7, 32'hFFFFFF80});
`else
    exp_q.push_back({5'd7, 32'h00000080});
`endif
    step();
    set_b(1'b0, 5'd0, 32'h0, 2'b10, 1'b0);
    step();
    @(negedge clk);
    check("b_latency_we", {31'b0, bus.write_enable}, 32'd1);
    step();
    set_b(1'b1, 5'd7, 32'h12345680, 2'b01, 1'b1);
    exp_q.push_back({5'd7, 32'h00005680});
    step();
    set_b(1'b0, 5'd0, 32'h0, 2'b10, 1'b0);
    repeat (3) step();

    // Starvation: A every cycle, one B entry
    set_a(1'b1, 5'd1, 32'hA0000001);
    set_b(1'b1, 5'd9, 32'h11111111, 2'b10, 1'b0);
    exp_q.push_back({5'd1, 32'hA0000001});
    step();
    set_b(1'b0, 5'd0, 32'h0, 2'b10, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      set_a(1'b1, 5'(k), 32'hA0000000 + 32'(k));
      check("starve_a_ready_hi", {31'b0, bus.a_ready}, 32'd1);
      exp_q.push_back({5'(k), 32'hA0000000 + 32'(k)});
      step();
    end
    set_a(1'b1, 5'd5, 32'hA0000005);
    check("starve_a_ready_lo", {31'b0, bus.a_ready}, 32'd0);
    exp_q.push_back({5'd9, 32'h11111111});
    step();
    check("starve_release", {31'b0, bus.a_ready}, 32'd1);
    exp_q.push_back({5'd5, 32'hA0000005});
    step();

    // FIFO full under saturated A
    for (int k = 0; k < 4; k++) begin
      set_a(1'b1, 5'(10 + k), 32'hC0000000 + 32'(k));
      set_b(1'b1, 5'(20 + k), 32'hB0000000 + 32'(k), 2'b10, 1'b0);
      exp_q.push_back({5'(10 + k), 32'hC0000000 + 32'(k)});
      step();
    end
    set_a(1'b1, 5'd14, 32'hC0000004);
    set_b(1'b1, 5'd24, 32'hB0000004, 2'b10, 1'b0);
    check("full_b_ready", {31'b0, bus.b_ready}, 32'd0);
    check("full_a_ready", {31'b0, bus.a_ready}, 32'd0);
    exp_q.push_back({5'd20, 32'hB0000000});
    step();
    set_a(1'b0, 5'd0, 32'h0);
    set_b(1'b0, 5'd0, 32'h0, 2'b10, 1'b0);
    for (int k = 1; k < 4; k++) exp_q.push_back({5'(20 + k), 32'hB0000000 + 32'(k)});
    repeat (4) step();
    check("drained_b_ready", {31'b0, bus.b_ready}, 32'd1);

    // x0 drop
    set_a(1'b1, 5'd0, 32'h55555555);
    check("x0_a_ready", {31'b0, bus.a_ready}, 32'd1);
    step();
    set_a(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("x0_we", {31'b0, bus.write_enable}, 32'd0);
    step();

    // Reset with two entries queued
    set_a(1'b1, 5'd27, 32'hE0000027);
    set_b(1'b1, 5'd25, 32'hF0000025, 2'b10, 1'b0);
    exp_q.push_back({5'd27, 32'hE0000027});
    step();
    set_a(1'b1, 5'd28, 32'hE0000028);
    set_b(1'b1, 5'd26, 32'hF0000026, 2'b10, 1'b0);
    exp_q.push_back({5'd28, 32'hE0000028});
    step();
    set_a(1'b0, 5'd0, 32'h0);
    set_b(1'b0, 5'd0, 32'h0, 2'b10, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_we", {31'b0, bus.write_enable}, 32'd0);
    check("mid_rst_b_ready", {31'b0, bus.b_ready}, 32'd1);
    repeat (5) step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
